rf_access_sequencer: RTL and testbench

Register-file access sequencer sitting directly upstream of the 32x32 dual-read register file. It accepts one instruction-level request (two source register addresses, one destination address, write-back flag). It then drives the register file's READ/WRITE/address/data pins through a read, capture, execute-wait and write-back sequence, and never asserts READ and WRITE together. Captured operands are handed to the execution stage. The result returned from that stage is written back to the register file.

---
 rtl/rf_access_sequencer_if.sv | 54 +++++
 rtl/rf_access_sequencer.sv | 147 ++++++++++++++
 tb/tb_rf_access_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_access_sequencer_if.sv
// Request, execution-result and register-file pin bundle for rf_access_sequencer.
// master = the sequencer, slave = requester / execution stage / register file side.
interface rf_access_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_rs;
    logic [ADDR_WIDTH-1:0] req_rt;
    logic [ADDR_WIDTH-1:0] req_rd;
    logic                  req_wb;

    logic                  opnd_valid;
    logic [DATA_WIDTH-1:0] opnd_a;
    logic [DATA_WIDTH-1:0] opnd_b;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;

    logic                  done;

    logic [ADDR_WIDTH-1:0] rf_addr_r1;
    logic [ADDR_WIDTH-1:0] rf_addr_r2;
    logic [ADDR_WIDTH-1:0] rf_addr_w;
    logic [DATA_WIDTH-1:0] rf_data_w;
    logic                  rf_read;
    logic                  rf_write;
    logic [DATA_WIDTH-1:0] rf_data_r1;
    logic [DATA_WIDTH-1:0] rf_data_r2;

    modport master (
        input  req_valid, req_rs, req_rt, req_rd, req_wb,
        output req_ready,
        output opnd_valid, opnd_a, opnd_b,
        input  res_valid, res_data,
        output res_ready,
        output done,
        output rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w, rf_read, rf_write,
        input  rf_data_r1, rf_data_r2
    );

    modport slave (
        output req_valid, req_rs, req_rt, req_rd, req_wb,
        input  req_ready,
        input  opnd_valid, opnd_a, opnd_b,
        output res_valid, res_data,
        input  res_ready,
        input  done,
        input  rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w, rf_read, rf_write,
        output rf_data_r1, rf_data_r2
    );
endinterface

// File: rtl/rf_access_sequencer.sv
// Sequences one instruction's register-file read, operand capture, execute wait and
// optional write-back; every output is a flop so nothing is combinational from inputs.
module rf_access_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rf_access_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        EXE  = 3'd3,
        WB   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] rs_q;
    logic [ADDR_WIDTH-1:0] rt_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  wb_q;

    logic [DATA_WIDTH-1:0] opnd_a_q;
    logic [DATA_WIDTH-1:0] opnd_b_q;
    logic [ADDR_WIDTH-1:0] addr_w_q;
    logic [DATA_WIDTH-1:0] data_w_q;

    logic req_ready_q, rf_read_q, rf_write_q, opnd_valid_q, res_ready_q, done_q;
    logic req_ready_d, rf_read_d, rf_write_d, opnd_valid_d, res_ready_d, done_d;

    logic accept;
    logic res_take;
    logic wb_go;

    // Handshakes qualified by the registered ready flags, so the cycle right after
    // reset release (ready still low) cannot accept anything.
    assign accept   = (state == IDLE) && req_ready_q && bus.req_valid;
    assign res_take = (state == EXE) && res_ready_q && bus.res_valid;
    assign wb_go    = res_take && wb_q && (rd_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RD;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = EXE;
            EXE:     if (res_take) state_nxt = wb_go ? WB : IDLE;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs are decoded from the upcoming state and registered.
    always_comb begin
        req_ready_d  = 1'b0;
        rf_read_d    = 1'b0;
        rf_write_d   = 1'b0;
        opnd_valid_d = 1'b0;
        res_ready_d  = 1'b0;
        done_d       = res_take;
        unique case (state_nxt)
            IDLE:    req_ready_d = 1'b1;
            RD:      rf_read_d   = 1'b1;
            CAP:     rf_read_d   = 1'b1;
            EXE: begin
                opnd_valid_d = 1'b1;
                res_ready_d  = 1'b1;
            end
            WB:      rf_write_d  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q  <= 1'b0;
            rf_read_q    <= 1'b0;
            rf_write_q   <= 1'b0;
            opnd_valid_q <= 1'b0;
            res_ready_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            req_ready_q  <= req_ready_d;
            rf_read_q    <= rf_read_d;
            rf_write_q   <= rf_write_d;
            opnd_valid_q <= opnd_valid_d;
            res_ready_q  <= res_ready_d;
            done_q       <= done_d;
        end
    end

    // Request latch, operand capture and write-back payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            opnd_a_q <= '0;
            opnd_b_q <= '0;
            addr_w_q <= '0;
            data_w_q <= '0;
        end else begin
            if (accept) begin
                rs_q <= bus.req_rs;
                rt_q <= bus.req_rt;
                rd_q <= bus.req_rd;
                wb_q <= bus.req_wb;
            end
            if (state == CAP) begin
                opnd_a_q <= bus.rf_data_r1;
                opnd_b_q <= bus.rf_data_r2;
            end
            if (wb_go) begin
                addr_w_q <= rd_q;
                data_w_q <= bus.res_data;
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.opnd_valid = opnd_valid_q;
    assign bus.opnd_a     = opnd_a_q;
    assign bus.opnd_b     = opnd_b_q;
    assign bus.res_ready  = res_ready_q;
    assign bus.done       = done_q;
    assign bus.rf_addr_r1 = rs_q;
    assign bus.rf_addr_r2 = rt_q;
    assign bus.rf_addr_w  = addr_w_q;
    assign bus.rf_data_w  = data_w_q;
    assign bus.rf_read    = rf_read_q;
    assign bus.rf_write   = rf_write_q;

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Bench for rf_access_sequencer: behavioural register file, directed vector table,
// reset corner sequences and randomized traffic against a golden register array.
module tb_rf_access_sequencer;

    logic clk;
    logic rst_n;

    rf_access_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    rf_access_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] rf_mem [32];
    logic [31:0] gold   [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    // Register file: addresses sampled on the edge while READ is high, writes on the edge while WRITE is high.
    always @(posedge clk) begin
        if (pl_en) begin
            rf_mem[pl_addr] <= pl_data;
        end else if (bus.rf_write) begin
            rf_mem[bus.rf_addr_w] <= bus.rf_data_w;
        end
        if (bus.rf_read) begin
            bus.rf_data_r1 <= (bus.rf_addr_r1 == 5'd0) ? 32'd0 : rf_mem[bus.rf_addr_r1];
            bus.rf_data_r2 <= (bus.rf_addr_r2 == 5'd0) ? 32'd0 : rf_mem[bus.rf_addr_r2];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 32'(act), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{bus.req_ready, bus.opnd_valid, bus.res_ready, bus.done, bus.rf_read,
                 bus.rf_write, bus.opnd_a, bus.opnd_b, bus.rf_data_w,
                 bus.rf_addr_r1, bus.rf_addr_r2, bus.rf_addr_w};
    endfunction

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] res;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_wr;
        int          stall;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic wb, input logic [31:0] res, input logic [31:0] ea,
                                input logic [31:0] eb, input logic ew, input int st);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd = rd; v.wb = wb; v.res = res;
        v.exp_a = ea; v.exp_b = eb; v.exp_wr = ew; v.stall = st;
        return v;
    endfunction

    // One full request; returns in the first IDLE cycle so a following call has zero gap.
    task automatic run_req(input vec_t v);
        chk1("accept_ready", bus.req_ready, 1'b1);
        bus.req_rs = v.rs; bus.req_rt = v.rt; bus.req_rd = v.rd; bus.req_wb = v.wb;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk1("rd_read", bus.rf_read, 1'b1);
        chk1("rd_write", bus.rf_write, 1'b0);
        chk("rd_addr_r1", 32'(bus.rf_addr_r1), 32'(v.rs));
        chk("rd_addr_r2", 32'(bus.rf_addr_r2), 32'(v.rt));
        chk1("rd_ready_low", bus.req_ready, 1'b0);
        tick();
        chk1("cap_read", bus.rf_read, 1'b1);
        chk1("cap_opnd_valid", bus.opnd_valid, 1'b0);
        if (v.stall == 0) begin
            bus.res_valid = 1'b1;
            bus.res_data  = v.res;
        end
        tick();
        chk1("exe_opnd_valid", bus.opnd_valid, 1'b1);
        chk("exe_opnd_a", bus.opnd_a, v.exp_a);
        chk("exe_opnd_b", bus.opnd_b, v.exp_b);
        chk1("exe_res_ready", bus.res_ready, 1'b1);
        chk1("exe_read", bus.rf_read, 1'b0);
        for (int i = 0; i < v.stall; i++) begin
            tick();
            chk1("stall_opnd_valid", bus.opnd_valid, 1'b1);
            chk("stall_opnd_a", bus.opnd_a, v.exp_a);
            chk("stall_opnd_b", bus.opnd_b, v.exp_b);
            chk1("stall_ready", bus.req_ready, 1'b0);
            chk1("stall_rdwr", bus.rf_read | bus.rf_write, 1'b0);
            chk1("stall_done", bus.done, 1'b0);
        end
        if (v.stall != 0) begin
            bus.res_valid = 1'b1;
            bus.res_data  = v.res;
        end
        tick();
        bus.res_valid = 1'b0;
        chk1("ret_done", bus.done, 1'b1);
        chk1("ret_write", bus.rf_write, v.exp_wr);
        chk1("ret_read", bus.rf_read, 1'b0);
        if (v.exp_wr) begin
            chk("wb_addr_w", 32'(bus.rf_addr_w), 32'(v.rd));
            chk("wb_data_w", bus.rf_data_w, v.res);
            chk1("wb_ready_low", bus.req_ready, 1'b0);
            gold[v.rd] = v.res;
            tick();
            chk1("post_wb_write", bus.rf_write, 1'b0);
            chk1("post_wb_done", bus.done, 1'b0);
        end
        chk1("idle_ready", bus.req_ready, 1'b1);
    endtask

    // Randomized-phase monitor: cycle-level expectations derived from accepted handshakes.
    logic        rnd_on = 1'b0;
    logic        m_pend = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_exp_a, m_exp_b;
    logic [4:0]  m_rd;
    logic        m_wb;
    logic        m_wr_next = 1'b0;
    logic [4:0]  m_wr_addr;
    logic [31:0] m_wr_data;
    logic        m_done_next = 1'b0;
    int          acc_cnt = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rnd_on) begin
            chk1("inv_read_and_write", bus.rf_read & bus.rf_write, 1'b0);
            chk1("rnd_write", bus.rf_write, m_wr_next);
            if (m_wr_next) begin
                chk("rnd_addr_w", 32'(bus.rf_addr_w), 32'(m_wr_addr));
                chk("rnd_data_w", bus.rf_data_w, m_wr_data);
                gold[m_wr_addr] = m_wr_data;
            end
            chk1("rnd_done", bus.done, m_done_next);
            if (bus.done) done_cnt++;
            m_wr_next   = 1'b0;
            m_done_next = 1'b0;
            if (m_pend) begin
                m_cnt++;
                if (m_cnt == 3) begin
                    chk1("rnd_opnd_valid", bus.opnd_valid, 1'b1);
                    chk("rnd_opnd_a", bus.opnd_a, m_exp_a);
                    chk("rnd_opnd_b", bus.opnd_b, m_exp_b);
                    m_pend = 1'b0;
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                m_done_next = 1'b1;
                if (m_wb && m_rd != 5'd0) begin
                    m_wr_next = 1'b1;
                    m_wr_addr = m_rd;
                    m_wr_data = bus.res_data;
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_cnt++;
                m_pend  = 1'b1;
                m_cnt   = 0;
                m_exp_a = gold[bus.req_rs];
                m_exp_b = gold[bus.req_rt];
                m_rd    = bus.req_rd;
                m_wb    = bus.req_wb;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vecs [5];
    logic take_req, take_res, drained;

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_rs = '0; bus.req_rt = '0; bus.req_rd = '0; bus.req_wb = 1'b0;
        bus.res_valid = 1'b0; bus.res_data = '0;
        pl_en = 1'b1; pl_addr = '0; pl_data = '0;

        for (int i = 0; i < 32; i++) begin
            pl_addr = 5'(i);
            pl_data = (i == 0) ? 32'd0 : (i == 5) ? 32'h0000_0011 : (i == 6) ? 32'h0000_0022
                                       : (32'h1000_0000 | 32'(i));
            gold[i] = pl_data;
            tick();
        end
        pl_en = 1'b0;
        chk1("reset_outputs_zero", any_out(), 1'b0);
        rst_n = 1'b1;
        chk1("release_ready_low", bus.req_ready, 1'b0);
        tick();
        chk1("first_ready", bus.req_ready, 1'b1);

        vecs[0] = mk(5'd5, 5'd6, 5'd7, 1'b1, 32'h0000_0033, 32'h11, 32'h22, 1'b1, 0);
        vecs[1] = mk(5'd7, 5'd0, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'h33, 32'h0, 1'b0, 0);
        vecs[2] = mk(5'd7, 5'd5, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h33, 32'h11, 1'b0, 0);
        vecs[3] = mk(5'd0, 5'd7, 5'd3, 1'b1, 32'hA5A5_A5A5, 32'h0, 32'h33, 1'b1, 0);
        vecs[4] = mk(5'd3, 5'd6, 5'd9, 1'b0, 32'h0BAD_F00D, 32'hA5A5_A5A5, 32'h22, 1'b0, 9);
        for (int i = 0; i < 5; i++) run_req(vecs[i]);
        chk("r0_unchanged", rf_mem[0], 32'd0);
        chk("r7_written", rf_mem[7], 32'h0000_0033);

        // Reset while in CAP: everything clears, nothing written.
        bus.req_rs = 5'd5; bus.req_rt = 5'd6; bus.req_rd = 5'd11; bus.req_wb = 1'b1;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk1("caprst_in_cap", bus.rf_read, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk1("caprst_outputs_zero", any_out(), 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        chk1("caprst_ready_low", bus.req_ready, 1'b0);
        tick();
        chk1("caprst_ready", bus.req_ready, 1'b1);
        chk("caprst_no_write", rf_mem[11], gold[11]);

        // Reset while in WB, before the committing edge.
        bus.req_rs = 5'd5; bus.req_rt = 5'd6; bus.req_rd = 5'd12; bus.req_wb = 1'b1;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.res_valid = 1'b1; bus.res_data = 32'h1234_5678;
        tick();
        tick();
        bus.res_valid = 1'b0;
        chk1("wbrst_in_wb", bus.rf_write, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk1("wbrst_outputs_zero", any_out(), 1'b0);
        tick();
        chk("wbrst_no_write", rf_mem[12], gold[12]);
        rst_n = 1'b1;
        chk1("wbrst_ready_low", bus.req_ready, 1'b0);
        tick();
        chk1("wbrst_ready", bus.req_ready, 1'b1);

        // Random traffic.
        rnd_on = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            take_req = bus.req_valid && bus.req_ready;
            take_res = bus.res_valid && bus.res_ready;
            tick();
            if (take_req) begin
                bus.req_valid = 1'b0;
            end else if (!bus.req_valid && $urandom_range(0, 3) == 0) begin
                bus.req_rs = 5'($urandom_range(0, 31));
                bus.req_rt = 5'($urandom_range(0, 31));
                bus.req_rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.req_wb = 1'($urandom_range(0, 1));
                bus.req_valid = 1'b1;
            end
            if (take_res) begin
                bus.res_valid = 1'b0;
            end else if (!bus.res_valid && $urandom_range(0, 2) == 0) begin
                bus.res_valid = 1'b1;
                bus.res_data  = $urandom;
            end
        end
        drained = 1'b0;
        for (int c = 0; c < 200 && !drained; c++) begin
            @(negedge clk);
            take_req = bus.req_valid && bus.req_ready;
            take_res = bus.res_valid && bus.res_ready;
            tick();
            if (take_req) bus.req_valid = 1'b0;
            if (take_res) bus.res_valid = 1'b0;
            else if (!bus.res_valid) begin
                bus.res_valid = 1'b1;
                bus.res_data  = $urandom;
            end
            if (!bus.req_valid && bus.req_ready && !m_pend && acc_cnt == done_cnt) drained = 1'b1;
        end
        bus.res_valid = 1'b0;
        tick();
        rnd_on = 1'b0;
        chk1("rnd_drained", drained, 1'b1);
        chk("done_count", 32'(done_cnt), 32'(acc_cnt));
        for (int i = 0; i < 32; i++) chk("final_regfile", rf_mem[i], gold[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
